// File: rtl/snn_mac_scheduler.sv
// Timestep controller for the spiking MAC datapath: streams one weight row per
// output neuron into the MAC, tracks the MAC latency with a valid/index shift
// register, and integrates each returned sum into a leaky membrane potential.
module snn_mac_scheduler #(
    parameter int S       = 25,
    parameter int W       = 16,
    parameter int N_NEUR  = 10,
    parameter int ADDR_W  = 4,
    parameter int VW      = 24,
    parameter int MAC_LAT = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                clear_v,
    input  logic [S-1:0]        spikes_in,
    input  logic [VW-1:0]       threshold,
    input  logic [VW-1:0]       leak,
    output logic [ADDR_W-1:0]   w_addr,
    input  logic [S*W-1:0]      w_data,
    output logic [S-1:0]        mac_pixels,
    output logic [S*W-1:0]      mac_weights,
    input  logic [20:0]         mac_sum,
    output logic [N_NEUR-1:0]   spike_out,
    output logic                busy,
    output logic                done,
    input  logic [ADDR_W-1:0]   v_sel,
    output logic [VW-1:0]       v_out
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    // Oldest pipeline stage; it lines up with the mac_sum of its neuron.
    localparam logic [MAC_LAT-1:0] LAST_STAGE = MAC_LAT'(1) << (MAC_LAT - 1);

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   cnt_reg;
    logic [S-1:0]        pix_reg;
    logic [VW-1:0]       thr_reg;
    logic [VW-1:0]       leak_reg;
    logic [MAC_LAT-1:0]  pv_reg;
    logic [ADDR_W-1:0]   pidx_reg [MAC_LAT];
    logic [VW-1:0]       v_reg [N_NEUR];

    logic                start_acc;
    logic                clear_acc;
    logic                issue_en;
    logic                last_issue;
    logic                tail_only;
    logic                upd_en;
    logic [ADDR_W-1:0]   upd_idx;
    logic [VW-1:0]       v_cur;
    logic [VW:0]         sum_ext;
    logic [VW-1:0]       v_sat;
    logic [VW-1:0]       v_leak;
    logic                fire;

    assign start_acc   = (state_reg == IDLE) && start;
    assign clear_acc   = (state_reg == IDLE) && clear_v && !start;
    assign last_issue  = (cnt_reg == ADDR_W'(N_NEUR - 1));
    // Only the oldest stage may still hold work: its update lands this cycle.
    assign tail_only   = ((pv_reg & ~LAST_STAGE) == '0);
    assign upd_en      = pv_reg[MAC_LAT-1];
    assign upd_idx     = pidx_reg[MAC_LAT-1];
    assign w_addr      = cnt_reg;
    assign mac_pixels  = pix_reg;
    assign mac_weights = w_data;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start)      state_next = RUN;
            RUN:     if (last_issue) state_next = DRAIN;
            DRAIN:   if (tail_only)  state_next = DONE;
            DONE:                    state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy     = (state_reg == RUN) || (state_reg == DRAIN);
        done     = (state_reg == DONE);
        issue_en = (state_reg == RUN);
    end

    // Row issue counter and per-timestep operand latches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg  <= '0;
            pix_reg  <= '0;
            thr_reg  <= '0;
            leak_reg <= '0;
        end else if (start_acc) begin
            cnt_reg  <= '0;
            pix_reg  <= spikes_in;
            thr_reg  <= threshold;
            leak_reg <= leak;
        end else if (issue_en) begin
            cnt_reg  <= last_issue ? '0 : cnt_reg + 1'b1;
        end
    end

    // Valid/index shift register tracking rows in flight through the MAC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv_reg <= '0;
            for (int i = 0; i < MAC_LAT; i++) pidx_reg[i] <= '0;
        end else begin
            pv_reg[0]   <= issue_en;
            pidx_reg[0] <= cnt_reg;
            for (int i = 1; i < MAC_LAT; i++) begin
                pv_reg[i]   <= pv_reg[i-1];
                pidx_reg[i] <= pidx_reg[i-1];
            end
        end
    end

    // Select the membrane being updated this cycle.
    always_comb begin
        v_cur = '0;
        for (int k = 0; k < N_NEUR; k++)
            if (upd_idx == ADDR_W'(k)) v_cur = v_reg[k];
    end

    // Integrate with saturation, apply leak with a floor at zero, then test.
    always_comb begin
        sum_ext = {1'b0, v_cur} + (VW+1)'(mac_sum);
        v_sat   = sum_ext[VW] ? '1 : sum_ext[VW-1:0];
        v_leak  = (v_sat > leak_reg) ? (v_sat - leak_reg) : '0;
        fire    = (v_leak >= thr_reg);
    end

    // Per-neuron membrane potential and output spike bit.
    generate
        for (genvar gi = 0; gi < N_NEUR; gi++) begin : g_neur
            logic hit;
            assign hit = upd_en && (upd_idx == ADDR_W'(gi));

            // Membrane: cleared on request, else replaced by the update result.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)            v_reg[gi] <= '0;
                else if (clear_acc) v_reg[gi] <= '0;
                else if (hit)       v_reg[gi] <= fire ? '0 : v_leak;
            end

            // Spike bit: cleared at timestep start, set when this neuron fires.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)              spike_out[gi] <= 1'b0;
                else if (start_acc)   spike_out[gi] <= 1'b0;
                else if (hit && fire) spike_out[gi] <= 1'b1;
            end
        end
    endgenerate

    // Membrane readout; unused selects read as zero.
    always_comb begin
        v_out = '0;
        for (int k = 0; k < N_NEUR; k++)
            if (v_sel == ADDR_W'(k)) v_out = v_reg[k];
    end

endmodule

// File: tb/tb_snn_mac_scheduler.sv
// Bench for snn_mac_scheduler: models the weight ROM and a two-register MAC,
// keeps a reference membrane model, and checks each timestep from a scoreboard.
module tb_snn_mac_scheduler;

    localparam int S       = 25;
    localparam int W       = 16;
    localparam int N_NEUR  = 10;
    localparam int ADDR_W  = 4;
    localparam int VW      = 24;
    localparam int MAC_LAT = 3;
    localparam longint VMAX = (64'd1 << VW) - 1;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic                clear_v = 1'b0;
    logic [S-1:0]        spikes_in = '0;
    logic [VW-1:0]       threshold = '0;
    logic [VW-1:0]       leak = '0;
    logic [ADDR_W-1:0]   w_addr;
    logic [S*W-1:0]      w_data = '0;
    logic [S-1:0]        mac_pixels;
    logic [S*W-1:0]      mac_weights;
    logic [20:0]         mac_sum = '0;
    logic [20:0]         mac_s1 = '0;
    logic [N_NEUR-1:0]   spike_out;
    logic                busy;
    logic                done;
    logic [ADDR_W-1:0]   v_sel = '0;
    logic [VW-1:0]       v_out;

    logic [W-1:0]        rom_w = 16'd1;
    longint              vm [N_NEUR];

    typedef struct packed {
        logic [N_NEUR-1:0]    spk;
        logic [N_NEUR*VW-1:0] v;
    } exp_t;
    exp_t q[$];

    int n_checks = 0;
    int n_fail   = 0;

    snn_mac_scheduler #(
        .S(S), .W(W), .N_NEUR(N_NEUR), .ADDR_W(ADDR_W), .VW(VW), .MAC_LAT(MAC_LAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .clear_v(clear_v),
        .spikes_in(spikes_in), .threshold(threshold), .leak(leak),
        .w_addr(w_addr), .w_data(w_data), .mac_pixels(mac_pixels),
        .mac_weights(mac_weights), .mac_sum(mac_sum), .spike_out(spike_out),
        .busy(busy), .done(done), .v_sel(v_sel), .v_out(v_out)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] dot(input logic [S*W-1:0] wv, input logic [S-1:0] px);
        int unsigned acc = 0;
        for (int i = 0; i < S; i++)
            if (px[i]) acc += int'(wv[i*W +: W]);
        return 21'(acc);
    endfunction

    // Synchronous ROM (every row identical) followed by a two-register MAC.
    always @(posedge clk) begin
        w_data  <= {S{rom_w}};
        mac_s1  <= dot(mac_weights, mac_pixels);
        mac_sum <= mac_s1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Reference model of one timestep; returns the expected outputs.
    task automatic model_ts(input logic [S-1:0] spk, input longint thr, input longint lk,
                            output exp_t e);
        longint s = 0;
        longint t;
        logic [63:0] tv;
        e = '0;
        for (int i = 0; i < S; i++) if (spk[i]) s += longint'(rom_w);
        for (int k = 0; k < N_NEUR; k++) begin
            t = vm[k] + s;
            if (t > VMAX) t = VMAX;
            t = (t > lk) ? t - lk : 0;
            if (t >= thr) begin
                e.spk[k] = 1'b1;
                vm[k] = 0;
            end else begin
                vm[k] = t;
            end
            tv = 64'(vm[k]);
            e.v[k*VW +: VW] = tv[VW-1:0];
        end
    endtask

    task automatic check_all_v(input string tag, input logic [N_NEUR*VW-1:0] ev);
        for (int k = 0; k < N_NEUR; k++) begin
            v_sel = ADDR_W'(k);
            #1;
            check($sformatf("%s_v%0d", tag, k), 32'(v_out), 32'(ev[k*VW +: VW]));
        end
    endtask

    function automatic logic [N_NEUR*VW-1:0] model_v();
        logic [N_NEUR*VW-1:0] r = '0;
        logic [63:0] tv;
        for (int k = 0; k < N_NEUR; k++) begin
            tv = 64'(vm[k]);
            r[k*VW +: VW] = tv[VW-1:0];
        end
        return r;
    endfunction

    // One timestep: push expectation, pulse start, follow the run, pop and compare.
    task automatic run_ts(input logic [S-1:0] spk, input logic [VW-1:0] thr,
                          input logic [VW-1:0] lk, input bit timing, input bit with_clear);
        exp_t e;
        int c;
        bit seen;
        model_ts(spk, longint'(thr), longint'(lk), e);
        q.push_back(e);
        @(negedge clk);
        spikes_in = spk; threshold = thr; leak = lk; start = 1'b1; clear_v = with_clear;
        @(negedge clk);
        start = 1'b0; clear_v = 1'b0;
        spikes_in = S'($urandom); threshold = VW'($urandom); leak = VW'($urandom);
        seen = 1'b0;
        for (c = 0; c < 40; c++) begin
            if (c > 0) @(negedge clk);
            if (timing && c < N_NEUR) check($sformatf("w_addr_c%0d", c), 32'(w_addr), 32'(c));
            if (timing && c == 0) check("busy_run", 32'(busy), 32'd1);
            if (timing && c == 4) start = 1'b1;
            if (timing && c == 5) start = 1'b0;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        check("done_cycle", seen ? 32'(c) : 32'hFFFF, 32'(N_NEUR + MAC_LAT));
        e = q.pop_front();
        check("spike_out", 32'(spike_out), 32'(e.spk));
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        check("spike_hold", 32'(spike_out), 32'(e.spk));
        check_all_v("ts", e.v);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        for (int k = 0; k < N_NEUR; k++) vm[k] = 0;

        // Reset
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_spike_out", 32'(spike_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_w_addr", 32'(w_addr), 32'd0);
        check_all_v("rst", model_v());
        v_sel = 4'd12; #1;
        check("v_out_oob", 32'(v_out), 32'd0);

        // Integrate and fire, with timing check and an ignored second start
        rom_w = 16'd1;
        run_ts({S{1'b1}}, 24'd60, 24'd0, 1'b1, 1'b0);
        run_ts({S{1'b1}}, 24'd60, 24'd0, 1'b0, 1'b0);
        run_ts({S{1'b1}}, 24'd60, 24'd0, 1'b0, 1'b0);

        // start together with clear_v: start wins, no clear
        run_ts({S{1'b1}}, 24'd60, 24'd0, 1'b0, 1'b0);
        run_ts({S{1'b1}}, 24'd60, 24'd0, 1'b0, 1'b1);

        // clear_v alone
        @(negedge clk); clear_v = 1'b1;
        @(negedge clk); clear_v = 1'b0;
        for (int k = 0; k < N_NEUR; k++) vm[k] = 0;
        check_all_v("clear", model_v());

        // Leak floor
        for (int t = 0; t < 5; t++) run_ts({S{1'b1}}, 24'd60, 24'd30, 1'b0, 1'b0);

        // Partial spike pattern
        run_ts(25'h0_0F0F0, 24'd20, 24'd0, 1'b0, 1'b0);
        @(negedge clk); clear_v = 1'b1;
        @(negedge clk); clear_v = 1'b0;
        for (int k = 0; k < N_NEUR; k++) vm[k] = 0;

        // Saturation
        rom_w = 16'hFFFF;
        for (int t = 0; t < 11; t++) run_ts({S{1'b1}}, 24'hFFFFFF, 24'd0, 1'b0, 1'b0);

        // Async reset mid-RUN
        rom_w = 16'd1;
        run_ts({S{1'b1}}, 24'd60, 24'd0, 1'b0, 1'b0);
        @(negedge clk);
        spikes_in = {S{1'b1}}; threshold = 24'd60; leak = 24'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (c = 0; c < 20 && w_addr != 4'd5; c++) @(negedge clk);
        check("reach_addr5", 32'(w_addr), 32'd5);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_spike_out", 32'(spike_out), 32'd0);
        check("arst_w_addr", 32'(w_addr), 32'd0);
        for (int k = 0; k < N_NEUR; k++) vm[k] = 0;
        check_all_v("arst", model_v());
        @(negedge clk);
        rst = 1'b0;
        run_ts({S{1'b1}}, 24'd60, 24'd0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/snn_mac_scheduler.md
Name: snn_mac_scheduler

Overview:
Timestep controller for the 25-input spiking MAC datapath. On each start pulse it streams one weight row per output neuron from a synchronous weight ROM into the MAC. The spike vector is held constant for the whole timestep. The controller tracks the MAC pipeline latency and integrates each returned sum into a per-neuron membrane potential with leak, threshold and reset, producing the layer's output spike vector.

Parameters:
S, 25, synapses per neuron (MAC input count)
W, 16, weight width
N_NEUR, 10, output neurons sequenced per timestep
ADDR_W, 4, weight ROM address width (>= clog2(N_NEUR))
VW, 24, membrane potential width (unsigned)
MAC_LAT, 3, cycles from w_addr issue to matching mac_sum valid

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  begin one timestep; accepted only in IDLE
clear_v  in  1  zero all membrane potentials; honoured only in IDLE
spikes_in  in  S  input spike vector, sampled when start is accepted
threshold  in  VW  firing threshold, sampled when start is accepted
leak  in  VW  per-timestep leak, sampled when start is accepted
w_addr  out  ADDR_W  weight ROM row address
w_data  in  S*W  ROM row, valid one cycle after w_addr
mac_pixels  out  S  spike vector to MAC (latched copy)
mac_weights  out  S*W  weights to MAC (combinational pass-through of w_data)
mac_sum  in  21  MAC registered sum, unsigned
spike_out  out  N_NEUR  output spikes for the last timestep, bit k = neuron k
busy  out  1  high in RUN/DRAIN
done  out  1  one-cycle pulse when timestep complete
v_sel  in  ADDR_W  membrane readout select
v_out  out  VW  combinational readout of v[v_sel]; 0 if v_sel >= N_NEUR

Behaviour:
- Reset (async, any state): FSM=IDLE; w_addr, mac_pixels, spike_out, busy, done = 0; all v[k]=0; pipeline valid bits cleared. Resetting mid-timestep discards the timestep with no partial update.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 -> latch spikes_in/threshold/leak, clear spike_out, issue counter=0, go RUN. start has priority over clear_v when both are asserted; clear_v is ignored then. clear_v alone zeros all v in one cycle.
- RUN: w_addr=issue counter, one row per cycle, addresses 0..N_NEUR-1 in order. The neuron index enters a MAC_LAT-deep valid/index shift register. After issuing N_NEUR-1 -> DRAIN.
- DRAIN: stay until the shift register is empty -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE.
- start in RUN/DRAIN/DONE is ignored: no restart, no relatch.
- Latency: with the start cycle as cycle -1, address i is driven in cycle i and mac_sum for neuron i is valid in cycle i+MAC_LAT. The update is applied at the end of that cycle. done is high in cycle N_NEUR+MAC_LAT. Total is N_NEUR+MAC_LAT+1 cycles start-to-done (14 by default).
- Update for neuron k, in this order:
  - t = v[k] + mac_sum, saturating at 2^VW-1.
  - t = (t > leak) ? t-leak : 0.
  - If t >= threshold: spike_out[k]=1 and v[k]=0. Otherwise v[k]=t.
- Leak applies every timestep, including when all spikes are 0.
- v persists across timesteps until clear_v or rst.
- spike_out is stable from done until the next accepted start.
- busy=1 in RUN and DRAIN only.

Test Plan:
- Reset: hold rst 3 cycles, release -> spike_out=0, busy=0, done=0, v_out=0 for all v_sel 0..9.
- Integrate/fire: ROM all weights 1, spikes all 1 (sum 25), threshold 60, leak 0.
  - After timestep 1: v=25. After timestep 2: v=50. Timestep 3 -> spike_out=10'h3FF, v=0.
- Timing: one start -> w_addr 0..9 on consecutive cycles, done high exactly 14 cycles after the start cycle. A second start at busy cycle 4 has no effect.
- Leak floor: same stimulus with leak 30 -> v stays 0 and spike_out=0 over 5 timesteps.
- Saturation: weights 0xFFFF, spikes all 1 (sum 1638375), threshold 2^24-1, leak 0.
  - After timestep 10: v=16383750, no spike.
  - Timestep 11 saturates to 16777215 -> spike_out all ones, v=0.
- Async reset mid-RUN: rst asserted while w_addr=5 -> busy=0 immediately, v all 0, spike_out=0. Next start behaves as the first timestep from reset. Separately, clear_v in IDLE -> v all 0.
